// File: rtl/seq_det_ctrl.sv
// Serial-job controller that feeds a sequence detector and counts its matches per job.
// Define SEQ_DET_CTRL_ABORT_EN to add the abort input that cancels a running job.
module seq_det_ctrl #(
  parameter int WIDTH = 8,
  parameter int DRAIN = 3,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
`ifdef SEQ_DET_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             ack0,
  output logic             ack1,
  output logic             det_b,
  output logic             det_rst,
  input  logic             det_w,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] hits
);

  // state   | meaning
  // S_IDLE  | waiting for a request; grant issued here
  // S_CLR   | detector held in reset, hit counter cleared
  // S_SHIFT | captured word driven onto det_b, MSB first
  // S_DRAIN | zeros fed so patterns ending at the LSB still complete
  // S_DONE  | done pulse, hits/done_id published
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_SHIFT, S_DRAIN, S_DONE} state_t;

  localparam int TMAX = (WIDTH > DRAIN) ? WIDTH : DRAIN;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] SHIFT_LD = TW'(WIDTH - 1);
  localparam logic [TW-1:0] DRAIN_LD = TW'(DRAIN - 1);

  state_t           state_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] word_q;
  logic             id_q;
  logic [TW-1:0]    tmr_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] hit_cnt_d;
  logic [CNT_W-1:0] hits_q;
  logic             done_q;
  logic             done_id_q;
  logic             busy_q;
  logic             det_b_q;
  logic             det_rst_q;
  logic             grant_vld;
  logic             grant_sel;
  logic             abort_hit;

  always_comb begin
    grant_vld = Rst && (state_q == S_IDLE) && (req0 || req1);
    grant_sel = (req0 && req1) ? ~last_grant_q : req1;
    hit_cnt_d = (det_w && (hit_cnt_q != '1)) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
  end

`ifdef SEQ_DET_CTRL_ABORT_EN
  assign abort_hit = abort && ((state_q == S_CLR) || (state_q == S_SHIFT) ||
                               (state_q == S_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  // Grant is decided in the IDLE cycle itself so the word is captured on the
  // edge that closes the ack pulse; the requester sees ack while still in IDLE.
  assign ack0    = grant_vld && !grant_sel;
  assign ack1    = grant_vld && grant_sel;
  assign det_b   = det_b_q;
  assign det_rst = det_rst_q || abort_hit;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign hits    = hits_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      word_q       <= '0;
      id_q         <= 1'b0;
      tmr_q        <= '0;
      hit_cnt_q    <= '0;
      hits_q       <= '0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      busy_q       <= 1'b0;
      det_b_q      <= 1'b0;
      det_rst_q    <= 1'b1;
    end else begin
      done_q    <= 1'b0;
      det_b_q   <= 1'b0;
      det_rst_q <= 1'b0;
      if (abort_hit) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (grant_vld) begin
              word_q       <= grant_sel ? data1 : data0;
              id_q         <= grant_sel;
              last_grant_q <= grant_sel;
              det_rst_q    <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= S_CLR;
            end
          end
          S_CLR: begin
            hit_cnt_q <= '0;
            det_b_q   <= word_q[WIDTH-1];
            word_q    <= {word_q[WIDTH-2:0], 1'b0};
            tmr_q     <= SHIFT_LD;
            state_q   <= S_SHIFT;
          end
          S_SHIFT: begin
            hit_cnt_q <= hit_cnt_d;
            if (tmr_q == '0) begin
              tmr_q   <= DRAIN_LD;
              state_q <= S_DRAIN;
            end else begin
              tmr_q   <= tmr_q - TW'(1);
              det_b_q <= word_q[WIDTH-1];
              word_q  <= {word_q[WIDTH-2:0], 1'b0};
            end
          end
          S_DRAIN: begin
            hit_cnt_q <= hit_cnt_d;
            if (tmr_q == '0) begin
              hits_q    <= hit_cnt_d;
              done_id_q <= id_q;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              tmr_q <= tmr_q - TW'(1);
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: table vectors, corner sequences and random jobs against a pattern-count model.
// The attached detector flags non-overlapping "110"/"101" windows with a registered w output.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, det_b, det_rst, busy, done, done_id;
  logic       det_w = 1'b0;
  logic [3:0] hits;
`ifdef SEQ_DET_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif

  seq_det_ctrl dut (
    .Clk(clk), .Rst(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
`ifdef SEQ_DET_CTRL_ABORT_EN
    .abort(abort),
`endif
    .ack0(ack0), .ack1(ack1), .det_b(det_b), .det_rst(det_rst), .det_w(det_w),
    .busy(busy), .done(done), .done_id(done_id), .hits(hits)
  );

  always #5 clk = ~clk;

  // detector environment model
  logic [1:0] dh = 2'b00;
  int         dn = 0;
  always @(posedge clk) begin
    if (det_rst) begin
      dn    <= 0;
      det_w <= 1'b0;
    end else begin
      if (dn >= 2 && ({dh, det_b} == 3'b110 || {dh, det_b} == 3'b101)) begin
        det_w <= 1'b1;
        dn    <= 0;
      end else begin
        det_w <= 1'b0;
        dn    <= (dn < 2) ? dn + 1 : 2;
      end
    end
    dh <= {dh[0], det_b};
  end

  int total = 0;
  int bad   = 0;
  int prev_hits = 0;
  bit lg = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // expected hit count: scan the full fed bit stream for non-overlapping matches;
  // a match is only counted if its registered flag lands inside SHIFT/DRAIN
  function automatic int ref_hits(input logic [7:0] w);
    int b[$];
    int cnt = 0;
    int start = 0;
    for (int i = 7; i >= 0; i--) b.push_back(int'(w[i]));
    for (int i = 0; i < 3; i++) b.push_back(0);
    for (int i = 0; i < b.size(); i++) begin
      if (i - start >= 2) begin
        int pat = b[i-2] * 4 + b[i-1] * 2 + b[i];
        if (pat == 6 || pat == 5) begin
          if (i <= b.size() - 2) cnt++;
          start = i + 1;
        end
      end
    end
    return (cnt > 15) ? 15 : cnt;
  endfunction

  // Called at the negedge where requests were just driven; returns at the done negedge.
  task automatic run_one(input bit sel, input logic [7:0] w, input int exp_hits,
                         input bit hold, input string nm);
    int n = 0;
    bit got = 0;
    bit stray_ack = 0, busy_err = 0, rst_err = 0;
    logic [10:0] bits = '0;
    #1;
    chk({nm, " ack0"}, ack0, !sel);
    chk({nm, " ack1"}, ack1, sel);
    chk({nm, " idle busy"}, busy, 0);
    chk({nm, " idle done"}, done, 0);
    chk({nm, " held hits"}, hits, prev_hits);
    lg = sel;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (!hold) begin
        req0  = (n >= 2 && n <= 11) ? 1'($urandom_range(0, 1)) : 1'b0;
        req1  = (n >= 2 && n <= 11) ? 1'($urandom_range(0, 1)) : 1'b0;
        data0 = 8'($urandom);
        data1 = 8'($urandom);
      end
      #1;
      if (ack0 || ack1) stray_ack = 1;
      if (!busy) busy_err = 1;
      if (n == 1) begin
        chk({nm, " clr det_rst"}, det_rst, 1);
        chk({nm, " clr det_b"}, det_b, 0);
      end
      if (n >= 2 && n <= 12) begin
        bits = {bits[9:0], det_b};
        if (det_rst) rst_err = 1;
      end
      if (done) got = 1;
    end
    chk({nm, " done seen"}, got, 1);
    chk({nm, " latency"}, n, 13);
    chk({nm, " det_b stream"}, bits, {w, 3'b000});
    chk({nm, " hits"}, hits, exp_hits);
    chk({nm, " done_id"}, done_id, sel);
    chk({nm, " stray ack"}, stray_ack, 0);
    chk({nm, " busy"}, busy_err, 0);
    chk({nm, " det_rst in job"}, rst_err, 0);
    chk({nm, " done det_b"}, det_b, 0);
    prev_hits = exp_hits;
  endtask

  typedef struct {
    bit         sel;
    logic [7:0] data;
    int         hits;
    string      nm;
  } vec_t;

  vec_t tbl[5];
  bit   rr_exp[3];

  initial begin
    tbl[0] = '{0, 8'hC0, 1, "C0"};
    tbl[1] = '{1, 8'hAA, 2, "AA"};
    tbl[2] = '{0, 8'hFF, 1, "FF"};
    tbl[3] = '{0, 8'h00, 0, "00"};
    tbl[4] = '{0, 8'h01, 0, "01"};
    rr_exp = '{0, 1, 0};

    rst_n = 1'b0; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
    repeat (2) @(negedge clk);
    req0 = 1;
    #1;
    chk("reset ack0", ack0, 0);
    chk("reset det_rst", det_rst, 1);
    chk("reset det_b", det_b, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset hits", hits, 0);
    req0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle det_rst", det_rst, 0);

    // round robin with both requests held
    @(negedge clk);
    req0 = 1; req1 = 1; data0 = 8'hC0; data1 = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      run_one(rr_exp[k], rr_exp[k] ? 8'hAA : 8'hC0, rr_exp[k] ? 2 : 1, 1, $sformatf("rr%0d", k));
      @(negedge clk);
    end
    req0 = 0; req1 = 0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tbl[i].sel) begin req1 = 1; data1 = tbl[i].data; end
      else begin req0 = 1; data0 = tbl[i].data; end
      run_one(tbl[i].sel, tbl[i].data, tbl[i].hits, 0, {"vec ", tbl[i].nm});
    end

    for (int j = 0; j < 30; j++) begin
      logic [1:0] v;
      bit es;
      logic [7:0] d0, d1;
      @(negedge clk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      v  = 2'($urandom_range(1, 3));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      es = (v[0] && v[1]) ? !lg : v[1];
      req0 = v[0]; req1 = v[1]; data0 = d0; data1 = d1;
      run_one(es, es ? d1 : d0, ref_hits(es ? d1 : d0), 0, $sformatf("rand%0d", j));
    end

    // reset in the 4th SHIFT cycle
    @(negedge clk);
    req1 = 1; data1 = 8'hAA;
    run_one(1, 8'hAA, 2, 0, "pre-reset");
    @(negedge clk);
    req0 = 1; data0 = 8'hFF;
    #1;
    chk("mid ack0", ack0, 1);
    begin
      bit done_seen = 0;
      for (int n = 1; n <= 5; n++) begin
        @(negedge clk);
        req0 = 0;
        if (done) done_seen = 1;
      end
      rst_n = 1'b0;
      #1;
      chk("mid rst det_rst", det_rst, 1);
      chk("mid rst det_b", det_b, 0);
      chk("mid rst busy", busy, 0);
      chk("mid rst done_id", done_id, 0);
      chk("mid rst hits", hits, 0);
      req0 = 1;
      #1;
      chk("mid rst ack0", ack0, 0);
      repeat (2) begin
        @(negedge clk);
        if (done) done_seen = 1;
      end
      rst_n = 1'b1; req0 = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) done_seen = 1;
      end
      chk("mid rst no done", done_seen, 0);
    end
    lg = 1; prev_hits = 0;
    req0 = 1; req1 = 1; data0 = 8'hC0; data1 = 8'hAA;
    run_one(0, 8'hC0, 1, 0, "post-reset");

`ifdef SEQ_DET_CTRL_ABORT_EN
    @(negedge clk);
    req0 = 1; data0 = 8'hFF;
    #1;
    chk("abort ack0", ack0, 1);
    begin
      bit done_seen = 0;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        req0 = 0;
      end
      @(negedge clk);
      abort = 1;
      #1;
      chk("abort det_rst", det_rst, 1);
      @(negedge clk);
      abort = 0;
      #1;
      chk("abort idle busy", busy, 0);
      chk("abort idle det_rst", det_rst, 0);
      repeat (15) begin
        @(negedge clk);
        if (done) done_seen = 1;
      end
      chk("abort no done", done_seen, 0);
      chk("abort hits kept", hits, prev_hits);
    end
    @(negedge clk);
    req1 = 1; data1 = 8'hAA;
    run_one(1, 8'hAA, 2, 0, "post-abort");
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of serial bits per job (2..15).
REQ-002 Parameter DRAIN, default 3, SHALL set the number of trailing zero bits fed after each job (>=3).
REQ-003 Parameter CNT_W, default 4, SHALL set the width of the hit count (2^CNT_W > WIDTH+DRAIN).
REQ-004 Clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Rst  input  1  asynchronous, active-low reset.
REQ-006 req0, req1  input  1 each  job request, level, held until acked.
REQ-007 data0, data1  input  WIDTH each  job word for requester 0/1.
REQ-008 ack0, ack1  output  1 each  one-cycle grant pulse; data captured on the same edge.
REQ-009 det_b  output  1  serial bit to the detector's B input.
REQ-010 det_rst  output  1  active-high synchronous reset to the detector's Rst input.
REQ-011 det_w  input  1  registered match flag from the detector's w output.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle job-complete pulse.
REQ-014 done_id  output  1  requester index of the completed job, valid with done.
REQ-015 hits  output  CNT_W  number of matches in the completed job, valid with done, held until the next done.

Function
REQ-016 The FSM SHALL have states IDLE, CLR, SHIFT, DRAIN and DONE.
REQ-017 IDLE: if any req is high, grant one request, pulse the matching ackN, capture dataN and its index, and go to CLR.
REQ-018 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; last_grant resets to 1, so req0 wins first.
REQ-019 CLR SHALL last 1 cycle with det_rst=1 and det_b=0, clear the hit counter, then go to SHIFT.
REQ-020 SHIFT SHALL last WIDTH cycles and drive det_b with the captured word MSB first, one bit per cycle.
REQ-021 DRAIN SHALL last DRAIN cycles with det_b=0; trailing zeros completing a pattern (e.g. "11" then 0) SHALL count as hits.
REQ-022 In every SHIFT and DRAIN cycle, det_w=1 SHALL increment the hit counter by 1; it SHALL saturate at all-ones.
REQ-023 DONE SHALL last 1 cycle: done=1, hits and done_id updated, then go to IDLE; no grant is issued in DONE.
REQ-024 Grant-to-done latency SHALL be exactly WIDTH+DRAIN+2 cycles (11+2=13 at defaults).
REQ-025 A request deasserted mid-job SHALL NOT affect the running job; requests SHALL be ignored outside IDLE.
REQ-026 det_rst SHALL be 0 and det_b SHALL be 0 in IDLE and DONE.

Reset
REQ-027 Rst low SHALL immediately force IDLE, ack0=ack1=0, det_b=0, det_rst=1, busy=0, done=0, done_id=0, hits=0, last_grant=1.
REQ-028 Rst asserted mid-job SHALL abandon the job with no done pulse; after release the FSM SHALL start from IDLE.

Configuration
REQ-029 With SEQ_DET_CTRL_ABORT_EN defined, the block SHALL add input abort (1 bit); abort=1 in CLR, SHIFT or DRAIN SHALL drive det_rst=1 for that cycle and return to IDLE with no done pulse and hits unchanged.
REQ-030 Without SEQ_DET_CTRL_ABORT_EN, the abort port SHALL NOT exist and every job SHALL run to DONE.

Verification
REQ-031 req0=1, data0=8'hC0 -> ack0 pulse, det_b=1,1,0,0,0,0,0,0,0,0,0; done 13 cycles after ack0, hits=1, done_id=0.
REQ-032 req1=1, data1=8'hAA -> hits=2, done_id=1.
REQ-033 data0=8'hFF -> hits=1 (match completed by a DRAIN zero); data0=8'h00 -> hits=0; data0=8'h01 -> hits=0.
REQ-034 req0 and req1 both held high for 3 jobs -> grants in order 0,1,0; busy stays high except 1 IDLE cycle between jobs.
REQ-035 Rst pulled low on the 4th SHIFT cycle -> all outputs take their reset values immediately, no done; the next job gives correct hits.
REQ-036 With SEQ_DET_CTRL_ABORT_EN defined, abort=1 in DRAIN -> det_rst=1 for that cycle, IDLE next, no done, hits keeps its previous value.
